// File: rtl/floo_pkg.sv
// Shared FlooNoC link types and mesh-wide constants.
// Imported by the link buffer and the mesh top-level.
package floo_pkg;

  localparam int unsigned LinkBufDepth = 2;
  localparam int unsigned LinkCntWidth = 32;

  typedef struct packed {
    logic [LinkCntWidth-1:0] flit_cnt;
    logic [LinkCntWidth-1:0] stall_cnt;
  } link_perf_t;

endpackage

// File: rtl/floo_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module floo_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/floo_link_buffer.sv
// Fully registered elastic buffer for one FlooNoC link channel.
// valid, ready and data all leave from flops; no fall-through.
module floo_link_buffer
  import floo_pkg::*;
#(
  parameter type         flit_t   = logic [63:0],
  parameter int unsigned Depth    = LinkBufDepth,
  parameter int unsigned CntWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  flit_t                      data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output flit_t                      data_o,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic [CntWidth-1:0]        flit_cnt_o,
  output logic [CntWidth-1:0]        stall_cnt_o
);

  localparam int unsigned UsageW = $clog2(Depth+1);
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [PtrW-1:0] ptr_t;

  flit_t             mem [Depth];
  ptr_t              wptr, rptr;
  logic [UsageW-1:0] cnt;
  logic              push, pop, stall;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth-1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign ready_o = (cnt != UsageW'(Depth));
  assign valid_o = (cnt != '0);
  assign data_o  = mem[rptr];
  assign usage_o = cnt;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign stall   = valid_o & ~ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      cnt <= cnt + UsageW'(push) - UsageW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (push && !clear_i) begin
      mem[wptr] <= data_i;
    end
  end

  floo_sat_counter #(.Width(CntWidth)) u_flit_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (pop),
    .cnt_o   (flit_cnt_o)
  );

  floo_sat_counter #(.Width(CntWidth)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (stall),
    .cnt_o   (stall_cnt_o)
  );

  a_depth_min : assert property (
    @(posedge clk_i) Depth >= 2);

  a_no_push_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push && (cnt == UsageW'(Depth))));

  a_data_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (stall && !clear_i) |=> $stable(data_o));

endmodule

// File: doc/floo_link_buffer.md
Name: floo_link_buffer

Overview:
- Elastic, fully registered buffer for one FlooNoC link channel (narrow req, narrow rsp or wide) between a router output port of one compute tile and the matching router input port of the neighbouring tile.
- Cuts every combinational path across the tile boundary: valid, data and ready are all driven from flops.
- Sustains 1 flit/cycle.
- Provides occupancy and saturating flit and stall counters for link performance monitoring.
- Instantiated once per channel per direction in the mesh top-level.

Parameters:
- flit_t, logic [63:0], payload type carried (floo_req_chan_t / floo_rsp_chan_t / floo_wide_chan_t).
- Depth, 2, number of entries; legal range 2..16; 2 is the minimum for full throughput with registered ready.
- CntWidth, 32, width of the perf counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of contents and counters.
- valid_i  in  1  upstream flit valid.
- ready_o  out  1  upstream ready; registered.
- data_i  in  $bits(flit_t)  upstream flit.
- valid_o  out  1  downstream valid; registered.
- ready_i  in  1  downstream ready.
- data_o  out  $bits(flit_t)  downstream flit, read from storage.
- usage_o  out  $clog2(Depth+1)  current occupancy.
- flit_cnt_o  out  CntWidth  flits forwarded downstream.
- stall_cnt_o  out  CntWidth  cycles with valid_o=1 and ready_i=0.

Behaviour:
Reset and interface
- One clock. Reset is asynchronous and active-low (rst_ni); all state clears immediately on assertion.
- Values under reset: ready_o=1, valid_o=0, data_o=0, usage_o=0, counters=0.
- Handshakes:
  - push = valid_i & ready_o
  - pop = valid_o & ready_i
  - Standard valid/ready. Once valid_o=1, data_o stays stable until pop.
  - Upstream may drop valid_i without penalty.

Storage and timing
- Storage is a circular array of Depth entries with write pointer wptr, read pointer rptr, and count cnt. Pointers wrap from Depth-1 to 0; Depth need not be a power of 2.
- ready_o = (cnt != Depth), decoded from the cnt register only; no path from valid_i or ready_i.
- valid_o = (cnt != 0).
- data_o = mem[rptr].
- Latency: a flit pushed in cycle N is visible on valid_o/data_o in cycle N+1 at the earliest. There is no fall-through, even when empty.
- cnt_next = cnt + push - pop.

Boundary conditions
- Empty, with push and no pop: cnt becomes 1 and valid_o rises next cycle.
- Full: ready_o=0, so no push is possible. A pop in the same cycle makes ready_o=1 next cycle. With Depth=2 and the downstream always ready, throughput is 1 flit/cycle.
- Simultaneous push and pop at cnt=1: cnt stays 1, both pointers advance, data_o updates to the new flit next cycle.

Clear
- clear_i=1 sets wptr, rptr, cnt and both counters to 0 at the next edge, and dominates any push or pop in that cycle.
- A handshake that completes in the clear cycle is dropped. The integrator drives clear_i only when the link is quiesced.

Counters
- flit_cnt_o increments on pop.
- stall_cnt_o increments when valid_o & !ready_i.
- Both saturate at 2^CntWidth-1 with no wrap. Both are readable while saturated.

Assertions (simulation only)
- Depth >= 2.
- No push when full.
- data_o stable while valid_o & !ready_i.

Decomposition:
- Add to floo_pkg:
  - the typedef link_perf_t {flit_cnt, stall_cnt}
  - the constant LinkBufDepth = 2, for mesh-wide use.
- Natural sub-module: floo_sat_counter (enable, clear, saturating increment), instantiated twice.
- The mesh top-level wraps three floo_link_buffer instances (req, rsp, wide) per link direction. The NoC's request struct combines its req-valid with the rsp-ready, so that wrapper splits and reassembles the valid/ready fields.

Test Plan:
- Reset mid-stream: 1 flit held with ready_i=0, then rst_ni pulsed low for half a cycle -> valid_o=0, ready_o=1, usage_o=0 immediately; counters read 0.
- Streaming: Depth=2, ready_i=1, 100 consecutive flits with data 0..99 -> outputs 0..99 in order, first out at cycle 1 after the first push, no bubbles; flit_cnt_o=100, stall_cnt_o=0.
- Backpressure fill: ready_i=0, valid_i=1 with data A, B, C -> A and B accepted, ready_o=0 from the cycle after B, C held. ready_i then raised -> A, B, C out in order; stall_cnt_o counts all cycles with valid_o=1 and ready_i=0.
- Depth=3 wrap-around: random valid_i/ready_i with 50% probability each, 1000 flits -> order preserved, usage_o never exceeds 3, scoreboard matches, flit_cnt_o=1000.
- Clear with push and pop in the same cycle: 2 entries held, clear_i=1 asserted with valid_i=1 and ready_i=1 -> next cycle usage_o=0, valid_o=0, counters=0, pushed flit discarded.
- Saturation: CntWidth=4, 20 pops -> flit_cnt_o reads 15 and stays at 15.
